// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between a fetch port and a load/store port
module mem_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int ADDR_SIZE    = 16,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req,
    input  logic [ADDR_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ack,
    output logic                 busy,
    output logic                 mem_on,
    output logic                 mem_w,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_din,
    input  logic [WORD_SIZE-1:0] mem_dout
);
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state;
    logic          owner_d;
    logic          we;
    logic [CW-1:0] starve;
    logic          grant_d;

    assign grant_d = d_req && (!i_req || starve < LIMIT);

    // Sequencer: latch the winner in IDLE, run one memory cycle, then acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner_d  <= 1'b0;
            we       <= 1'b0;
            starve   <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            busy     <= 1'b0;
            mem_on   <= 1'b0;
            mem_w    <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state    <= ACCESS;
                        owner_d  <= grant_d;
                        we       <= grant_d && d_we;
                        mem_addr <= grant_d ? d_addr : i_addr;
                        mem_din  <= grant_d ? d_wdata : '0;
                        mem_on   <= 1'b1;
                        mem_w    <= grant_d && d_we;
                        busy     <= 1'b1;
                        if (i_req && d_req)
                            starve <= grant_d ? ((starve == LIMIT) ? starve : starve + 1'b1) : '0;
                        else if (i_req)
                            starve <= '0;
                    end
                end
                ACCESS: begin
                    state  <= DONE;
                    mem_on <= 1'b0;
                    mem_w  <= 1'b0;
                    if (!we && owner_d)
                        d_rdata <= mem_dout;
                    if (!we && !owner_d)
                        i_rdata <= mem_dout;
                    d_ack <= owner_d;
                    i_ack <= !owner_d;
                end
                DONE: begin
                    state <= IDLE;
                    d_ack <= 1'b0;
                    i_ack <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, corner sequences and randomized traffic against a transaction model
module tb_mem_arbiter;
    localparam int LIM = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_din, mem_dout;
    logic        i_ack, d_ack, busy, mem_on, mem_w;

    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;

    int vectors = 0;
    int errors = 0;
    logic [15:0] exp_i_rd = '0;
    logic [15:0] exp_d_rd = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.WORD_SIZE(16), .ADDR_SIZE(16), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .busy(busy),
        .mem_on(mem_on), .mem_w(mem_w), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Memory model: combinational read while enabled and not writing, write at the edge
    assign mem_dout = (mem_on && !mem_w) ? mem[mem_addr[7:0]] : '0;

    always @(posedge clk) begin
        if (load_en)
            mem[load_addr] <= load_data;
        else if (mem_on && mem_w)
            mem[mem_addr[7:0]] <= mem_din;
    end

    typedef struct {
        logic        ir;
        logic [15:0] ia;
        logic        dr;
        logic        dwe;
        logic [15:0] da;
        logic [15:0] dwd;
        logic        exp_d;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction starting with the DUT idle; optionally raises a fetch during ACCESS
    task automatic run_txn(input logic ir, input logic [15:0] ia, input logic dr, input logic dwe,
                           input logic [15:0] da, input logic [15:0] dwd, input logic wd,
                           input logic [15:0] erd, input logic late_i, input logic [15:0] late_a);
        i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        @(posedge clk); #1;
        chk("access mem_on", mem_on, 1);
        chk("access mem_w", mem_w, wd && dwe);
        chk("access mem_addr", mem_addr, wd ? da : ia);
        if (wd && dwe) chk("access mem_din", mem_din, dwd);
        chk("access busy", busy, 1);
        chk("access acks", {i_ack, d_ack}, 0);
        if (late_i) begin
            i_req = 1'b1;
            i_addr = late_a;
        end
        @(posedge clk); #1;
        chk("done i_ack", i_ack, !wd);
        chk("done d_ack", d_ack, wd);
        chk("done mem_on", mem_on, 0);
        chk("done mem_w", mem_w, 0);
        chk("done busy", busy, 1);
        if (wd && dwe) begin
            ref_mem[da[7:0]] = dwd;
            chk("store landed", mem[da[7:0]], dwd);
        end else if (wd) exp_d_rd = erd;
        else exp_i_rd = erd;
        chk("i_rdata", i_rdata, exp_i_rd);
        chk("d_rdata", d_rdata, exp_d_rd);
        @(posedge clk); #1;
        chk("idle acks", {i_ack, d_ack}, 0);
        chk("idle busy", busy, 0);
    endtask

    initial begin
        logic        pi, pd, pdwe, wd, late;
        logic [15:0] pia, pda, pdwd, late_a, erd;
        int          cnt;
        tbl[0]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1004};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0005, 16'hBEEF, 1'b1, 16'h0000};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'hBEEF};
        for (int i = 3; i < 11; i++)
            tbl[i] = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0005, 16'h0000, (i != 6 && i != 10), (i == 6 || i == 10) ? 16'h1004 : 16'hBEEF};
        rst_n = 1'b0;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        i_addr = 16'h0003; d_addr = 16'h0007; d_wdata = 16'h5555;
        load_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            load_addr = 8'(i);
            load_data = (i == 0) ? 16'h1004 : (i == 4) ? 16'h0001 : 16'($urandom);
            ref_mem[i] = load_data;
            @(posedge clk); #1;
        end
        load_en = 1'b0;
        chk("reset outputs", {i_ack, d_ack, busy, mem_on, mem_w}, 0);
        chk("reset rdata", {i_rdata, d_rdata}, 0);
        chk("reset mem bus", {mem_addr, mem_din}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++)
            run_txn(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dwe, tbl[i].da, tbl[i].dwd,
                    tbl[i].exp_d, tbl[i].exp_rd, 1'b0, 16'h0000);
        // Reset arriving in the middle of a store
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0004; d_wdata = 16'h1234;
        @(posedge clk); #1;
        chk("midrst mem_w before", mem_w, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst mem_w", mem_w, 0);
        chk("midrst mem_on", mem_on, 0);
        d_req = 1'b0;
        @(posedge clk); #1;
        chk("midrst mem4 kept", mem[4], 16'h0001);
        chk("midrst no ack", {i_ack, d_ack}, 0);
        rst_n = 1'b1;
        exp_i_rd = '0;
        exp_d_rd = '0;
        @(posedge clk); #1;
        chk("midrst still no ack", {i_ack, d_ack, mem_on}, 0);
        chk("midrst rdata cleared", {i_rdata, d_rdata}, 0);
        // Fetch raised during a load's ACCESS waits for the next IDLE
        run_txn(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'hBEEF, 1'b1, 16'h0000);
        run_txn(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1004, 1'b0, 16'h0000);
        // Randomized traffic against the transaction model
        cnt = 0;
        pi = 1'b0; pd = 1'b0; pia = '0; pda = '0; pdwd = '0; pdwe = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!pi && $urandom_range(0, 1) == 1) begin
                pi = 1'b1;
                pia = 16'($urandom_range(0, 255));
            end
            if (!pd && $urandom_range(0, 2) != 0) begin
                pd = 1'b1;
                pdwe = 1'($urandom_range(0, 1));
                pda = 16'($urandom_range(0, 255));
                pdwd = 16'($urandom);
            end
            if (!pi && !pd) begin
                i_req = 1'b0;
                d_req = 1'b0;
                @(posedge clk); #1;
                chk("rand idle", {mem_on, busy}, 0);
                continue;
            end
            wd = (pi && pd) ? (cnt < LIM) : pd;
            if (wd && pi) cnt = (cnt < LIM) ? cnt + 1 : cnt;
            if (!wd) cnt = 0;
            erd = wd ? ref_mem[pda[7:0]] : ref_mem[pia[7:0]];
            late = wd && !pi && $urandom_range(0, 3) == 0;
            late_a = 16'($urandom_range(0, 255));
            run_txn(pi, pia, pd, pdwe, pda, pdwd, wd, erd, late, late_a);
            if (wd) pd = 1'b0;
            else pi = 1'b0;
            if (late) begin
                pi = 1'b1;
                pia = late_a;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
